// File: rtl/spi_master_arbiter_if.sv
// Requester-side and spi_master-side signals of spi_master_arbiter, bundled as one interface.
// The arbiter connects through the slave modport; the driving side uses the master modport.
interface spi_master_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
);
  // Requester side (two requesters, packed per requester)
  logic [1:0]              reqIn;
  logic [2*LEN_WIDTH-1:0]  lenIn;
  logic [2*DATA_WIDTH-1:0] txDataIn;
  logic [1:0]              grantOut;
  logic [1:0]              byteAckOut;
  logic [DATA_WIDTH-1:0]   rxDataOut;
  logic [1:0]              rxValidOut;
  logic [1:0]              doneOut;
  logic                    errOut;

  // SPI chip select and byte-level spi_master side
  logic                    spiCsLowOut;
  logic                    masterEnOut;
  logic [DATA_WIDTH-1:0]   masterTxOut;
  logic [DATA_WIDTH-1:0]   masterRxIn;
  logic                    masterDoneIn;

  modport slave (
    input  reqIn, lenIn, txDataIn, masterRxIn, masterDoneIn,
    output grantOut, byteAckOut, rxDataOut, rxValidOut, doneOut, errOut,
    output spiCsLowOut, masterEnOut, masterTxOut
  );

  modport master (
    output reqIn, lenIn, txDataIn, masterRxIn, masterDoneIn,
    input  grantOut, byteAckOut, rxDataOut, rxValidOut, doneOut, errOut,
    input  spiCsLowOut, masterEnOut, masterTxOut
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one byte-level spi_master between two requesters.
// Grants whole multi-byte transactions, owns chip select for the whole transaction,
// and routes received bytes, acks and completion pulses to the granted requester only.
// CS_SETUP, CS_GAP and TIMEOUT are assumed to be at least 2.
module spi_master_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned CS_SETUP   = 4,
  parameter int unsigned CS_GAP     = 8,
  parameter int unsigned TIMEOUT    = 4096
) (
  input logic                 clkIn,
  input logic                 rstIn,
  spi_master_arbiter_if.slave bus
);

  localparam int unsigned SetupW = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
  localparam int unsigned GapW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int unsigned ToW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLoad,
    StXfer,
    StGap
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [LEN_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [SetupW-1:0]     setup_cnt_q, setup_cnt_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [ToW-1:0]        to_cnt_q, to_cnt_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [1:0]            rx_valid_q, rx_valid_d;
  logic [1:0]            done_q, done_d;
  logic                  err_q, err_d;
  logic                  cs_low_n_q, cs_low_n_d;
  logic                  en_q, en_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;

  // Winner of the current IDLE decision and the selected requester's fields
  logic                  pick;
  logic [LEN_WIDTH-1:0]  len_sel;
  logic [DATA_WIDTH-1:0] tx_sel;

  // Round-robin pick: on contention the requester not granted last time wins
  always_comb begin
    pick    = (bus.reqIn == 2'b11) ? ~last_grant_q : bus.reqIn[1];
    len_sel = pick ? bus.lenIn[2*LEN_WIDTH-1:LEN_WIDTH] : bus.lenIn[LEN_WIDTH-1:0];
    tx_sel  = owner_q ? bus.txDataIn[2*DATA_WIDTH-1:DATA_WIDTH] : bus.txDataIn[DATA_WIDTH-1:0];
  end

  // Next-state and registered-output logic; pulse outputs default low every cycle
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    setup_cnt_d  = setup_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;
    grant_d      = grant_q;
    rx_data_d    = rx_data_q;
    cs_low_n_d   = cs_low_n_q;
    en_d         = en_q;
    tx_d         = tx_q;
    ack_d        = 2'b00;
    rx_valid_d   = 2'b00;
    done_d       = 2'b00;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|bus.reqIn) begin
          owner_d      = pick;
          last_grant_d = pick;
          byte_cnt_d   = len_sel;
          grant_d      = pick ? 2'b10 : 2'b01;
          cs_low_n_d   = 1'b0;
          setup_cnt_d  = '0;
          state_d      = StSetup;
        end
      end

      StSetup: begin
        if (setup_cnt_q == SetupW'(CS_SETUP - 1)) begin
          state_d = StLoad;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end

      StLoad: begin
        tx_d     = tx_sel;
        ack_d    = grant_q;
        en_d     = 1'b1;
        to_cnt_d = '0;
        state_d  = StXfer;
      end

      StXfer: begin
        if (bus.masterDoneIn) begin
          rx_data_d  = bus.masterRxIn;
          rx_valid_d = grant_q;
          en_d       = 1'b0;
          if (byte_cnt_q == '0) begin
            done_d     = grant_q;
            cs_low_n_d = 1'b1;
            grant_d    = 2'b00;
            gap_cnt_d  = '0;
            state_d    = StGap;
          end else begin
            byte_cnt_d = byte_cnt_q - 1'b1;
            state_d    = StLoad;
          end
        end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
          // spi_master never answered: abort the whole transaction
          err_d      = 1'b1;
          done_d     = grant_q;
          en_d       = 1'b0;
          cs_low_n_d = 1'b1;
          grant_d    = 2'b00;
          gap_cnt_d  = '0;
          state_d    = StGap;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StGap: begin
        if (gap_cnt_q == GapW'(CS_GAP - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset releases CS at once and favours requester 0
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      byte_cnt_q   <= '0;
      setup_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      to_cnt_q     <= '0;
      grant_q      <= 2'b00;
      ack_q        <= 2'b00;
      rx_data_q    <= '0;
      rx_valid_q   <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 1'b0;
      cs_low_n_q   <= 1'b1;
      en_q         <= 1'b0;
      tx_q         <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      setup_cnt_q  <= setup_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      to_cnt_q     <= to_cnt_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cs_low_n_q   <= cs_low_n_d;
      en_q         <= en_d;
      tx_q         <= tx_d;
    end
  end

  assign bus.grantOut    = grant_q;
  assign bus.byteAckOut  = ack_q;
  assign bus.rxDataOut   = rx_data_q;
  assign bus.rxValidOut  = rx_valid_q;
  assign bus.doneOut     = done_q;
  assign bus.errOut      = err_q;
  assign bus.spiCsLowOut = cs_low_n_q;
  assign bus.masterEnOut = en_q;
  assign bus.masterTxOut = tx_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: a small spi_master model answers each byte with
// tx ^ 8'hA6 after RESP_LAT cycles of masterEnOut; monitors count pulses and CS timing.
module tb_spi_master_arbiter;
  localparam int unsigned DW       = 8;
  localparam int unsigned LW       = 4;
  localparam int unsigned CS_SETUP = 4;
  localparam int unsigned CS_GAP   = 8;
  localparam int unsigned TIMEOUT  = 4096;
  localparam int          RESP_LAT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  spi_master_arbiter #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .CS_SETUP  (CS_SETUP),
    .CS_GAP    (CS_GAP),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clkIn(clk),
    .rstIn(rst),
    .bus  (bus)
  );

  // spi_master model
  logic          model_mute = 1'b0;
  logic          mdl_done;
  logic [DW-1:0] mdl_rx;
  int            lat_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_done <= 1'b0;
      mdl_rx   <= '0;
      lat_cnt  <= 0;
    end else if (mdl_done) begin
      mdl_done <= 1'b0;
      lat_cnt  <= 0;
    end else if (bus.masterEnOut && !model_mute) begin
      if (lat_cnt == RESP_LAT - 2) begin
        mdl_done <= 1'b1;
        mdl_rx   <= bus.masterTxOut ^ 8'hA6;
      end
      lat_cnt <= lat_cnt + 1;
    end else begin
      lat_cnt <= 0;
    end
  end

  assign bus.masterDoneIn = mdl_done;
  assign bus.masterRxIn   = mdl_rx;

  // Requester byte tables; the index advances on each byteAck
  logic [DW-1:0] tab0 [8];
  logic [DW-1:0] tab1 [8];
  int            idx0, idx1;
  assign bus.txDataIn = {tab1[idx1], tab0[idx0]};

  // Monitor
  logic clr = 1'b0;
  logic en_prev = 1'b0, cs_prev = 1'b1, grant_prev = 1'b0, err_prev = 1'b0;
  int   cyc = 0;
  int   n_ack0, n_ack1, n_rxv0, n_rxv1, n_done0, n_done1, n_err, n_en_rise, n_cs_rise;
  int   rxv0_at_done, err_cyc, en_cyc, cs_low_at_en, cs_low_len, cs_low_last;
  int   cs_high_run, cs_high_min, n_grants, rx_idx;
  logic done_at_err, cs_after_err;
  logic [DW-1:0] rx_log [8];
  int   grant_seq [8];

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    en_prev    <= bus.masterEnOut;
    cs_prev    <= bus.spiCsLowOut;
    grant_prev <= |bus.grantOut;
    err_prev   <= bus.errOut;
    if (clr) begin
      n_ack0 <= 0; n_ack1 <= 0; n_rxv0 <= 0; n_rxv1 <= 0; n_done0 <= 0; n_done1 <= 0;
      n_err <= 0; n_en_rise <= 0; n_cs_rise <= 0; rxv0_at_done <= 0; err_cyc <= 0;
      en_cyc <= 0; cs_low_at_en <= 0; cs_low_len <= 0; cs_low_last <= 0; cs_high_run <= 0;
      cs_high_min <= 1000000; n_grants <= 0; rx_idx <= 0; idx0 <= 0; idx1 <= 0;
      done_at_err <= 1'b0; cs_after_err <= 1'b0;
    end else begin
      if (bus.byteAckOut[0]) begin
        n_ack0 <= n_ack0 + 1;
        if (idx0 < 7) idx0 <= idx0 + 1;
      end
      if (bus.byteAckOut[1]) begin
        n_ack1 <= n_ack1 + 1;
        if (idx1 < 7) idx1 <= idx1 + 1;
      end
      if (bus.rxValidOut[0]) n_rxv0 <= n_rxv0 + 1;
      if (bus.rxValidOut[1]) n_rxv1 <= n_rxv1 + 1;
      if (|bus.rxValidOut && rx_idx < 8) begin
        rx_log[rx_idx] <= bus.rxDataOut;
        rx_idx         <= rx_idx + 1;
      end
      if (bus.doneOut[0]) begin
        n_done0      <= n_done0 + 1;
        rxv0_at_done <= n_rxv0 + int'(bus.rxValidOut[0]);
      end
      if (bus.doneOut[1]) n_done1 <= n_done1 + 1;
      if (bus.errOut) begin
        n_err       <= n_err + 1;
        err_cyc     <= cyc;
        done_at_err <= bus.doneOut[0];
      end
      if (err_prev) cs_after_err <= bus.spiCsLowOut;
      if (bus.masterEnOut && !en_prev) begin
        n_en_rise <= n_en_rise + 1;
        en_cyc    <= cyc;
        if (n_en_rise == 0) cs_low_at_en <= cs_low_len;
      end
      if (bus.spiCsLowOut && !cs_prev) begin
        n_cs_rise   <= n_cs_rise + 1;
        cs_low_last <= cs_low_len;
      end
      cs_low_len  <= bus.spiCsLowOut ? 0 : cs_low_len + 1;
      cs_high_run <= bus.spiCsLowOut ? cs_high_run + 1 : 0;
      if (|bus.grantOut && !grant_prev) begin
        if (n_grants < 8) grant_seq[n_grants] <= bus.grantOut[1] ? 1 : 0;
        if (n_grants > 0 && cs_high_run < cs_high_min) cs_high_min <= cs_high_run;
        n_grants <= n_grants + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cur(input int sel);
    case (sel)
      0:       return n_done0 + n_done1;
      1:       return n_rxv0;
      default: return n_ack0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int target, input int budget, input string tag);
    int k = 0;
    while (cur(sel) < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(cur(sel) >= target), 32'd1);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic settle();
    repeat (CS_GAP + 4) @(negedge clk);
    #1;
  endtask

  task automatic fill_tabs(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [DW-1:0] t1);
    for (int i = 0; i < 8; i++) begin
      tab0[i] = c;
      tab1[i] = t1;
    end
    tab0[0] = a;
    tab0[1] = b;
  endtask

  initial begin
    bus.reqIn = 2'b00;
    bus.lenIn = '0;
    fill_tabs(8'h0B, 8'h0B, 8'h0B, 8'h5C);
    clear_mon();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_cs", 32'(bus.spiCsLowOut), 32'd1);
    chk("reset_grant", 32'(bus.grantOut), 32'd0);
    chk("reset_pulses", 32'({bus.byteAckOut, bus.rxValidOut, bus.doneOut, bus.errOut}), 32'd0);
    chk("reset_master", 32'({bus.masterEnOut, bus.masterTxOut, bus.rxDataOut}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1) single byte from requester 0
    clear_mon();
    bus.lenIn = 8'h00;
    bus.reqIn = 2'b01;
    wait_for(0, 1, 200, "t1_done_wait");
    bus.reqIn = 2'b00;
    settle();
    chk("t1_ack0", 32'(n_ack0), 32'd1);
    chk("t1_rxv0", 32'(n_rxv0), 32'd1);
    chk("t1_rxdata", 32'(rx_log[0]), 32'hAD);
    chk("t1_done0", 32'(n_done0), 32'd1);
    chk("t1_cs_low_len", 32'(cs_low_last), 32'(CS_SETUP + 1 + 16));
    chk("t1_setup_len", 32'(cs_low_at_en), 32'(CS_SETUP + 1));
    chk("t1_other_quiet", 32'(n_ack1 + n_rxv1 + n_done1 + n_err), 32'd0);
    chk("t1_cs_idle", 32'(bus.spiCsLowOut), 32'd1);

    // 2) three-byte transaction
    fill_tabs(8'h0B, 8'h00, 8'h02, 8'h5C);
    clear_mon();
    bus.lenIn = 8'h02;
    bus.reqIn = 2'b01;
    wait_for(0, 1, 400, "t2_done_wait");
    bus.reqIn = 2'b00;
    settle();
    chk("t2_en_windows", 32'(n_en_rise), 32'd3);
    chk("t2_cs_rises", 32'(n_cs_rise), 32'd1);
    chk("t2_cs_low_len", 32'(cs_low_last), 32'(CS_SETUP + 3 * (1 + 16)));
    chk("t2_rx0", 32'(rx_log[0]), 32'hAD);
    chk("t2_rx1", 32'(rx_log[1]), 32'hA6);
    chk("t2_rx2", 32'(rx_log[2]), 32'hA4);
    chk("t2_rxv_at_done", 32'(rxv0_at_done), 32'd3);
    chk("t2_done0", 32'(n_done0), 32'd1);

    // 3) both requesting from reset: grants alternate 0,1,0,1
    @(negedge clk);
    rst = 1'b1;
    fill_tabs(8'h0B, 8'h0B, 8'h0B, 8'h5C);
    clear_mon();
    @(negedge clk);
    rst = 1'b0;
    bus.lenIn = 8'h00;
    bus.reqIn = 2'b11;
    wait_for(0, 4, 400, "t3_done_wait");
    bus.reqIn = 2'b00;
    settle();
    chk("t3_grants", 32'(n_grants), 32'd4);
    chk("t3_seq", 32'({grant_seq[0][1:0], grant_seq[1][1:0], grant_seq[2][1:0],
                       grant_seq[3][1:0]}), 32'b00_01_00_01);
    chk("t3_cs_gap", 32'(cs_high_min), 32'(CS_GAP + 1));
    chk("t3_done_split", 32'({n_done0[7:0], n_done1[7:0]}), 32'h0202);
    chk("t3_rx_req1", 32'(rx_log[1]), 32'hFA);
    chk("t3_ack1", 32'(n_ack1), 32'd2);

    // 4) spi_master never answers: timeout
    clear_mon();
    model_mute = 1'b1;
    bus.reqIn  = 2'b01;
    wait_for(0, 1, TIMEOUT + 200, "t4_done_wait");
    bus.reqIn = 2'b00;
    settle();
    model_mute = 1'b0;
    chk("t4_err", 32'(n_err), 32'd1);
    chk("t4_err_latency", 32'(err_cyc - en_cyc), 32'(TIMEOUT));
    chk("t4_done_with_err", 32'(done_at_err), 32'd1);
    chk("t4_cs_after_err", 32'(cs_after_err), 32'd1);
    chk("t4_no_rxv", 32'(n_rxv0), 32'd0);

    // 5) reset during the second byte, then restart
    fill_tabs(8'h11, 8'h22, 8'h33, 8'h5C);
    clear_mon();
    bus.lenIn = 8'h02;
    bus.reqIn = 2'b01;
    wait_for(1, 1, 200, "t5_byte1_wait");
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_cs", 32'(bus.spiCsLowOut), 32'd1);
    chk("t5_async_grant", 32'(bus.grantOut), 32'd0);
    chk("t5_async_en", 32'(bus.masterEnOut), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("t5_no_done", 32'(n_done0 + n_done1), 32'd0);
    clear_mon();
    @(negedge clk);
    rst = 1'b0;
    wait_for(0, 1, 400, "t5_done_wait");
    bus.reqIn = 2'b00;
    settle();
    chk("t5_restart_setup", 32'(cs_low_at_en), 32'(CS_SETUP + 1));
    chk("t5_ack0", 32'(n_ack0), 32'd3);
    chk("t5_rx", 32'({rx_log[0], rx_log[1], rx_log[2]}), 32'hB78495);

    // 6) request dropped mid-transaction
    fill_tabs(8'h44, 8'h55, 8'h66, 8'h5C);
    clear_mon();
    bus.lenIn = 8'h02;
    bus.reqIn = 2'b01;
    wait_for(2, 1, 200, "t6_ack_wait");
    bus.reqIn = 2'b00;
    wait_for(0, 1, 400, "t6_done_wait");
    settle();
    chk("t6_rxv0", 32'(n_rxv0), 32'd3);
    chk("t6_done0", 32'(n_done0), 32'd1);
    chk("t6_rx", 32'({rx_log[0], rx_log[1], rx_log[2]}), 32'hE2F3C0);
    chk("t6_single_grant", 32'(n_grants), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end
endmodule
